// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// byte-wide VALID/ACK holding register with framing-error and overrun status.
module uart_rx_byte #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, nxt;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [7:0]    shift;
    logic          store, ferr_hit;

    assign rx_s = sync[1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) sync <= 2'b11;
        else       sync <= {sync[0], RX};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) nxt = S_START;
            S_START: if (cnt == HALF_LAST) nxt = rx_s ? S_IDLE : S_DATA;
            // one extra cycle after the last sample before entering STOP
            S_DATA:  if (idx == 4'd8) nxt = S_STOP;
            S_STOP:  if (cnt == LAST) nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state != S_IDLE);
        store    = (state == S_STOP) && (cnt == LAST) && rx_s;
        ferr_hit = (state == S_STOP) && (cnt == LAST) && !rx_s;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else if (nxt != state) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            case (state)
                S_START, S_STOP: cnt <= cnt + CW'(1);
                S_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        idx   <= idx + 4'd1;
                        shift <= {rx_s, shift[7:1]};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // A store and an ACK in the same cycle hand over cleanly: VALID stays up.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= ferr_hit;
            if (store) DATA <= shift;
            if (store)                VALID <= 1'b1;
            else if (ACK && VALID)    VALID <= 1'b0;
            if (store && VALID && !ACK) OVERRUN <= 1'b1;
            else if (ACK)               OVERRUN <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- 8N1 UART receiver on the FTB0 serial input line.
- Produces a byte-wide result with a VALID/ACK handshake, plus framing-error and overrun status.
- Downstream logic consumes the byte, e.g. to drive the LED bus or a command decoder.
- Runs entirely in the CLK domain; RX is asynchronous to CLK and is synchronised internally.

Parameters:
- CLK_HZ, 100000000, CLK frequency in Hz.
- BAUD, 115200, line bit rate.
- DIV (localparam) = CLK_HZ/BAUD, integer division, truncated. Elaboration error if DIV < 4.
- HALF (localparam) = DIV/2, truncated.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous active-high reset.
- RX  input  1  serial line, idle high, asynchronous to CLK.
- DATA  output  8  last received byte, LSB = first data bit.
- VALID  output  1  byte available; held high until ACK.
- ACK  input  1  consumer accepts DATA; sampled on the CLK rising edge.
- FRAME_ERR  output  1  one-cycle pulse when the stop bit samples low.
- OVERRUN  output  1  sticky: a byte was overwritten while VALID was high.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous and active-high. While RESET is high:
  - sync FFs = 1, state = IDLE, counters = 0, shift = 0;
  - DATA = 0, VALID = 0, FRAME_ERR = 0, OVERRUN = 0, BUSY = 0.
- RESET asserted mid-frame aborts the frame silently: no VALID, no FRAME_ERR.
- Synchroniser: RX passes through 2 FFs to give rx_s. All decisions use rx_s only.
- Bit counter cnt and bit index idx are both zeroed on every state entry.
- IDLE:
  - if rx_s == 0 → START.
  - T0 is defined as this transition edge.
- START:
  - cnt increments each cycle.
  - at cnt == HALF-1: rx_s == 0 → DATA; rx_s == 1 → IDLE (glitch reject, no status).
- DATA:
  - at cnt == DIV-1: shift = {rx_s, shift[7:1]}, cnt = 0, idx++.
  - after idx 7 is sampled → STOP.
- STOP:
  - at cnt == DIV-1, rx_s == 1: DATA <= shift, VALID <= 1 → IDLE.
  - at cnt == DIV-1, rx_s == 0: FRAME_ERR = 1 for exactly one cycle; DATA and VALID unchanged → BREAK.
- BREAK:
  - wait for rx_s == 1 → IDLE. This prevents a held-low line from retriggering.
- Latency: the VALID rising edge occurs HALF + 9*DIV + 1 cycles after T0. DATA is stable from that same edge.
- Handshake:
  - ACK while VALID == 1 clears VALID on the next edge.
  - ACK while VALID == 0 is ignored.
- Simultaneous ACK and new-byte store in the same cycle:
  - VALID stays 1 and DATA takes the new byte;
  - OVERRUN is not set.
- Store while VALID == 1 and ACK == 0:
  - DATA is overwritten and VALID stays 1;
  - OVERRUN is set.
- OVERRUN clearing:
  - cleared by any ACK whose cycle does not also set it;
  - otherwise held until RESET.
- BUSY is combinational from state and is high in START, DATA, STOP and BREAK.

Test Plan (CLK_HZ=16, BAUD=1, so DIV=16 and HALF=8):
- Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), each bit 16 cycles → VALID rises exactly 153 cycles after T0, DATA=0xA5, FRAME_ERR never high, BUSY falls on the same edge.
- Pulse RX low for 4 cycles from idle → START rejects at cnt=7, state returns to IDLE, no VALID, no FRAME_ERR.
- Send 0x3C with a stop bit of 0, then hold RX low for 40 cycles, then release high → one FRAME_ERR pulse, VALID stays 0, no new frame starts until RX goes high.
- Send 0x11 with no ACK, then 0x22 → DATA=0x22, VALID=1, OVERRUN=1. Assert ACK for 1 cycle → VALID=0 and OVERRUN=0 on the next edge.
- Send 0x55 and assert ACK on the exact cycle 0x66 is stored → VALID=1, DATA=0x66, OVERRUN=0.
- Assert RESET asynchronously during the data bits of 0xFF → all outputs 0 immediately. After release, send 0x81 → DATA=0x81.
